// File: rtl/cpu_defines_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// Holds the MIPS load/store opcodes, bus size encodings, the access FSM
// state type and a helper that maps an opcode to its access size.
package cpu_defines_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_DRAIN
  } mem_state_t;

  // Anything that is not a half or word access is treated as a byte access.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: op_size = SIZE_HALF;
      OP_LW, OP_SW:         op_size = SIZE_WORD;
      default:              op_size = SIZE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// load_extend: selects the addressed byte/half lane of a 32-bit read word
// and sign- or zero-extends it according to the load opcode.
// Ports:
//   op      in  6   load opcode
//   addr_lo in  2   byte offset within the word
//   rdata   in  32  raw bus read data
//   data    out 32  extended load result
module load_extend
  import cpu_defines_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  data = {24'h0, byte_v};
      OP_LH:   data = {{16{half_v[15]}}, half_v};
      OP_LHU:  data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory access unit. Checks alignment, drives a
// split-transaction data bus (req/addr_ok then data_ok), returns extended
// load data and stalls the pipeline until the access completes.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i, pipe_hold_i   MEM-stage flush / external hold
//   memen_i rmem_i wmem_i  access enable, load, store
//   op_i addr_i wdata_i    opcode, effective address, store data
//   except_i               upstream exceptions (nonzero suppresses access)
//   data_*                 data bus request fields and responses
//   load_data_o            extended load result
//   stall_o                MEM stage must stall
//   adel_o ades_o          load/store address error, badvaddr_o = address
//
// state | meaning
// IDLE  | no access outstanding; request driven directly from inputs
// ADDR  | request presented, waiting addr_ok; fields from registered copy
// DATA  | address accepted, waiting data_ok
// DONE  | access finished while held; result served from latch
// DRAIN | flushed access still in flight; finish it and drop the result
module mem_access
  import cpu_defines_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              pipe_hold_i,
  input  logic              memen_i,
  input  logic              rmem_i,
  input  logic              wmem_i,
  input  logic [5:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [7:0]        except_i,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic              stall_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o
);

  mem_state_t state, state_nx;
  logic       drain_addr, drain_addr_nx;   // DRAIN still owes an addr_ok

  logic [5:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_load;

  logic [1:0]        size_c;
  logic [3:0]        wstrb_c;
  logic [DATA_W-1:0] wdata_c;
  logic              mis;
  logic              start;
  logic [DATA_W-1:0] ext;

  always_comb begin
    size_c = op_size(op_i);
    mis    = ((size_c == SIZE_HALF) && addr_i[0]) ||
             ((size_c == SIZE_WORD) && (addr_i[1:0] != 2'b00));
    wstrb_c = 4'b0000;
    wdata_c = wdata_i;
    case (size_c)
      SIZE_BYTE: begin
        wstrb_c = 4'b0001 << addr_i[1:0];
        wdata_c = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        wstrb_c = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_i[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = wdata_i;
      end
    endcase
    if (!wmem_i) wstrb_c = 4'b0000;
  end

  assign adel_o     = memen_i & rmem_i & mis;
  assign ades_o     = memen_i & wmem_i & mis;
  assign badvaddr_o = (adel_o | ades_o) ? addr_i : '0;
  assign start      = memen_i & (rmem_i | wmem_i) & ~flush_i &
                      (except_i == 8'h00) & ~mis;

  // Extension always uses the registered copy: the pipeline may already
  // present other values by the time data_ok returns.
  load_extend u_load_extend (
    .op      (r_op),
    .addr_lo (r_addr[1:0]),
    .rdata   (data_rdata_i),
    .data    (ext)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      drain_addr <= 1'b0;
    end else begin
      state      <= state_nx;
      drain_addr <= drain_addr_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op    <= '0;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_load  <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        r_op    <= op_i;
        r_addr  <= addr_i;
        r_wr    <= wmem_i;
        r_size  <= size_c;
        r_wstrb <= wstrb_c;
        r_wdata <= wdata_c;
      end
      if (state == ST_DATA && data_data_ok_i && pipe_hold_i && !flush_i)
        r_load <= ext;
    end
  end

  always_comb begin
    state_nx      = state;
    drain_addr_nx = drain_addr;
    data_req_o    = 1'b0;
    data_wr_o     = 1'b0;
    data_size_o   = '0;
    data_addr_o   = '0;
    data_wstrb_o  = '0;
    data_wdata_o  = '0;
    stall_o       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          data_req_o   = 1'b1;
          data_wr_o    = wmem_i;
          data_size_o  = size_c;
          data_addr_o  = addr_i;
          data_wstrb_o = wstrb_c;
          data_wdata_o = wdata_c;
          stall_o      = 1'b1;
          state_nx     = data_addr_ok_i ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        data_req_o   = 1'b1;
        data_wr_o    = r_wr;
        data_size_o  = r_size;
        data_addr_o  = r_addr;
        data_wstrb_o = r_wstrb;
        data_wdata_o = r_wdata;
        stall_o      = 1'b1;
        if (flush_i) begin
          state_nx      = ST_DRAIN;
          drain_addr_nx = ~data_addr_ok_i;
        end else if (data_addr_ok_i) begin
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        stall_o = ~data_data_ok_i;
        if (data_data_ok_i) begin
          // A flush alongside completion simply drops the result.
          state_nx = (pipe_hold_i && !flush_i) ? ST_DONE : ST_IDLE;
        end else if (flush_i) begin
          state_nx      = ST_DRAIN;
          drain_addr_nx = 1'b0;
        end
      end
      ST_DONE: begin
        if (!pipe_hold_i || flush_i) state_nx = ST_IDLE;
      end
      ST_DRAIN: begin
        stall_o = memen_i;
        if (drain_addr) begin
          data_req_o   = 1'b1;
          data_wr_o    = r_wr;
          data_size_o  = r_size;
          data_addr_o  = r_addr;
          data_wstrb_o = r_wstrb;
          data_wdata_o = r_wdata;
          if (data_addr_ok_i) drain_addr_nx = 1'b0;
        end else if (data_data_ok_i) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign load_data_o = (state == ST_DATA && data_data_ok_i) ? ext :
                       (state == ST_DONE)                   ? r_load : '0;

endmodule
